nand_input_debounce: RTL

//   Upstream conditioning stage for the NAND gate inputs. Takes two raw, asynchronous
//   pad bits (switches/buttons on ui_in[1:0]), synchronises them into clk and debounces

---
 rtl/nand_input_debounce.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/nand_input_debounce.sv
// Two-channel pad conditioner for the NAND inputs: reset synchroniser, 2-flop input
// synchronisers, and one debounce FSM per channel with edge pulses and glitch counters.

module nand_input_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16,
  parameter int GLITCH_W        = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                sync,
  output logic                clean,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch
);
  typedef enum logic [1:0] {S_LO, S_WAIT_HI, S_HI, S_WAIT_LO} state_t;

  // cnt holds (samples seen at the new level) - 1; the entering sample is sample 1,
  // so the level is accepted on the sample that finds cnt at DEBOUNCE_CYCLES-2.
  localparam logic [CNT_W-1:0] LAST   = CNT_W'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
  localparam bit               DIRECT = (DEBOUNCE_CYCLES == 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_LO;
      cnt    <= '0;
      clean  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= '0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (ena) begin
        case (state)
          S_LO: if (sync) begin
            if (DIRECT) begin
              state <= S_HI;
              clean <= 1'b1;
              rise  <= 1'b1;
            end else begin
              state <= S_WAIT_HI;
              cnt   <= '0;
            end
          end
          S_WAIT_HI: if (sync) begin
            if (cnt == LAST) begin
              state <= S_HI;
              cnt   <= '0;
              clean <= 1'b1;
              rise  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            state <= S_LO;
            cnt   <= '0;
            if (glitch != '1) glitch <= glitch + 1'b1;
          end
          S_HI: if (!sync) begin
            if (DIRECT) begin
              state <= S_LO;
              clean <= 1'b0;
              fall  <= 1'b1;
            end else begin
              state <= S_WAIT_LO;
              cnt   <= '0;
            end
          end
          S_WAIT_LO: if (!sync) begin
            if (cnt == LAST) begin
              state <= S_LO;
              cnt   <= '0;
              clean <= 1'b0;
              fall  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            state <= S_HI;
            cnt   <= '0;
            if (glitch != '1) glitch <= glitch + 1'b1;
          end
          default: state <= S_LO;
        endcase
      end
    end
  end
endmodule

module nand_input_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16,
  parameter int GLITCH_W        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [1:0]            raw_in,
  output logic [1:0]            clean_out,
  output logic [1:0]            rise_pulse,
  output logic [1:0]            fall_pulse,
  output logic [2*GLITCH_W-1:0] glitch_cnt
);
  localparam int NUM_LANES = 2;

  // Reset asserts asynchronously, releases two clk edges after rst_n rises.
  logic [1:0] rst_pipe;
  logic       rst_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= '0;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_i = rst_pipe[1];

  logic [NUM_LANES-1:0] meta, sync;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= raw_in;
      sync <= meta;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    nand_input_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .GLITCH_W       (GLITCH_W)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_i),
      .ena   (ena),
      .sync  (sync[i]),
      .clean (clean_out[i]),
      .rise  (rise_pulse[i]),
      .fall  (fall_pulse[i]),
      .glitch(glitch_cnt[i*GLITCH_W +: GLITCH_W])
    );
  end
endmodule
